// File: rtl/slp_timer_ctrl.sv
// ----------------------------------------------------------------------------
// slp_timer_ctrl
//
// Sequencing controller for a 3-digit BCD seven-segment counter chain.
// Turns raw start/pause/clear push-buttons into clean one-cycle commands.
// Drives the counter with one-cycle load/clear pulses and a prescaled
// count-enable strobe. Watches the counter's terminal flag to end a run,
// then holds a timed DONE indication before returning to IDLE.
//
// Parameters
//   TICK_DIV     clk cycles per count-enable strobe (>= 2)
//   DONE_HOLD    prescaler ticks that DONE is held before auto-return (>= 1)
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high; clears all state
//   start_btn    raw asynchronous button, active-high
//   pause_btn    raw asynchronous button, active-high
//   clear_btn    raw asynchronous button, active-high
//   cnt_terminal counter terminal flag, qualified by cnt_enable
//   cnt_enable   count-enable strobe to the counter
//   cnt_reset    one-cycle clear pulse to the counter
//   cnt_load     one-cycle load pulse to the counter
//   busy         high in LOAD, RUN and PAUSE
//   done         high in DONE
//   state        IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4
// ----------------------------------------------------------------------------
module slp_timer_ctrl #(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned DONE_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       clear_btn,
    input  logic       cnt_terminal,
    output logic       cnt_enable,
    output logic       cnt_reset,
    output logic       cnt_load,
    output logic       busy,
    output logic       done,
    output logic [2:0] state
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HW = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(DONE_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state_q, state_n;
    logic [PW-1:0] presc_q, presc_n;
    logic [HW-1:0] hold_q, hold_n;
    logic          load_n, clr_n, enable_n;

    // Button bit order everywhere below: {clear, pause, start}.
    logic [2:0] sync_meta, sync_stable, sync_prev;
    logic [2:0] press;

    logic cmd_clear, cmd_start, cmd_pause;
    logic tick, hold_last, strobe_hit;

    // Two-flop synchronizer followed by a one-flop history for edge detect.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, exactly like the hardware.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta   <= '0;
            sync_stable <= '0;
            sync_prev   <= '0;
        end else begin
            sync_meta   <= {clear_btn, pause_btn, start_btn};
            sync_stable <= sync_meta;
            sync_prev   <= sync_stable;
        end
    end

    assign press = sync_stable & ~sync_prev;

    // Only the highest-priority command of a cycle is delivered; a lower one
    // pressed in the same cycle is dropped rather than deferred.
    assign cmd_clear = press[2];
    assign cmd_start = press[0] & ~press[2];
    assign cmd_pause = press[1] & ~press[0] & ~press[2];

    assign tick       = (presc_q == PRESC_LAST);
    assign hold_last  = (hold_q == HOLD_LAST);
    // cnt_enable is our own registered strobe, so this sees exactly the
    // cycle in which the counter is being advanced.
    assign strobe_hit = cnt_enable & cnt_terminal;

    // Next-state and command-pulse decisions.
    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n = state_q;
        load_n  = 1'b0;
        clr_n   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_clear) begin
                    clr_n = 1'b1;
                end else if (cmd_start) begin
                    state_n = S_LOAD;
                    load_n  = 1'b1;
                end
            end
            S_LOAD: begin
                state_n = S_RUN;
            end
            S_RUN: begin
                // A terminal hit ends the run even if pause arrives together.
                if (cmd_clear) begin
                    state_n = S_IDLE;
                    clr_n   = 1'b1;
                end else if (strobe_hit) begin
                    state_n = S_DONE;
                end else if (cmd_pause) begin
                    state_n = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (cmd_clear) begin
                    state_n = S_IDLE;
                    clr_n   = 1'b1;
                end else if (cmd_start || cmd_pause) begin
                    state_n = S_RUN;
                end
            end
            S_DONE: begin
                if (cmd_clear) begin
                    state_n = S_IDLE;
                    clr_n   = 1'b1;
                end else if (cmd_start) begin
                    state_n = S_LOAD;
                    load_n  = 1'b1;
                end else if (tick && hold_last) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Prescaler, hold counter and count-enable strobe.
    always_comb begin
        presc_n  = presc_q;
        hold_n   = hold_q;
        enable_n = 1'b0;
        if (state_n == S_IDLE || state_n == S_LOAD ||
            (state_n == S_DONE && state_q != S_DONE)) begin
            // Fresh start of a run, or DONE entered: its hold window is
            // timed from zero so it lasts exactly DONE_HOLD*TICK_DIV cycles.
            presc_n = '0;
            hold_n  = '0;
        end else if (state_n == state_q && (state_q == S_RUN || state_q == S_DONE)) begin
            presc_n = tick ? '0 : presc_q + PW'(1);
            if (state_q == S_RUN) begin
                enable_n = tick;
            end else if (tick) begin
                hold_n = hold_q + HW'(1);
            end
        end
        // Any other transition (RUN<->PAUSE, LOAD->RUN) or PAUSE itself keeps
        // the prescaler frozen, and no strobe is issued on a leaving edge.
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            hold_q     <= '0;
            cnt_enable <= 1'b0;
            cnt_reset  <= 1'b0;
            cnt_load   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_n;
            presc_q    <= presc_n;
            hold_q     <= hold_n;
            cnt_enable <= enable_n;
            cnt_reset  <= clr_n;
            cnt_load   <= load_n;
            busy       <= (state_n == S_LOAD) || (state_n == S_RUN) || (state_n == S_PAUSE);
            done       <= (state_n == S_DONE);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_slp_timer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_slp_timer_ctrl
//
// Self-checking bench for slp_timer_ctrl with TICK_DIV=4, DONE_HOLD=3.
// A behavioural model steps once per clock and queues the expected output
// vector; a monitor on the falling edge pops and compares it with the DUT.
// Directed scenarios are followed by a randomized phase.
// ----------------------------------------------------------------------------
module tb_slp_timer_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int DONE_HOLD = 3;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_RUN   = 2;
    localparam int M_PAUSE = 3;
    localparam int M_DONE  = 4;

    logic       clk          = 1'b0;
    logic       reset        = 1'b1;
    logic       start_btn    = 1'b0;
    logic       pause_btn    = 1'b0;
    logic       clear_btn    = 1'b0;
    logic       cnt_terminal = 1'b0;
    logic       cnt_enable;
    logic       cnt_reset;
    logic       cnt_load;
    logic       busy;
    logic       done;
    logic [2:0] state;
    logic [7:0] dut_vec;

    slp_timer_ctrl #(
        .TICK_DIV (TICK_DIV),
        .DONE_HOLD(DONE_HOLD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_btn   (start_btn),
        .pause_btn   (pause_btn),
        .clear_btn   (clear_btn),
        .cnt_terminal(cnt_terminal),
        .cnt_enable  (cnt_enable),
        .cnt_reset   (cnt_reset),
        .cnt_load    (cnt_load),
        .busy        (busy),
        .done        (done),
        .state       (state)
    );

    always #5 clk = ~clk;

    assign dut_vec = {state, cnt_enable, cnt_reset, cnt_load, busy, done};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b, expected %b (state,en,rst,load,busy,done)",
                     name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: button presses from sampled history, run progress as
    // elapsed RUN cycles (strobe on every multiple of TICK_DIV), DONE as
    // elapsed cycles against DONE_HOLD*TICK_DIV.
    // ------------------------------------------------------------------
    int         m_mode       = M_IDLE;
    int         run_elapsed  = 0;
    int         done_elapsed = 0;
    bit         m_en         = 1'b0;
    bit         m_load       = 1'b0;
    bit         m_rst        = 1'b0;
    logic [2:0] samples[$];
    logic [7:0] exp_q[$];

    function automatic logic [7:0] model_vec();
        return {3'(m_mode), m_en, m_rst, m_load,
                (m_mode >= M_LOAD && m_mode <= M_PAUSE), (m_mode == M_DONE)};
    endfunction

    task automatic model_reset();
        m_mode       = M_IDLE;
        run_elapsed  = 0;
        done_elapsed = 0;
        m_en         = 1'b0;
        m_load       = 1'b0;
        m_rst        = 1'b0;
        samples      = '{3'b000, 3'b000, 3'b000};
        exp_q.delete();
    endtask

    task automatic model_step();
        logic [2:0] p;
        bit c_clr, c_st, c_ps, hit, new_en;
        // samples holds the button values seen at the three previous edges;
        // a command acts two edges after its first high sample.
        p     = samples[1] & ~samples[0];
        void'(samples.pop_front());
        samples.push_back({clear_btn, pause_btn, start_btn});
        c_clr  = p[2];
        c_st   = p[0] && !p[2];
        c_ps   = p[1] && !p[0] && !p[2];
        hit    = m_en && (cnt_terminal === 1'b1);
        new_en = 1'b0;
        m_load = 1'b0;
        m_rst  = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (c_clr) m_rst = 1'b1;
                else if (c_st) begin m_mode = M_LOAD; m_load = 1'b1; end
            end
            M_LOAD: begin
                m_mode      = M_RUN;
                run_elapsed = 0;
            end
            M_RUN: begin
                if (c_clr) begin m_mode = M_IDLE; m_rst = 1'b1; end
                else if (hit) begin m_mode = M_DONE; done_elapsed = 0; end
                else if (c_ps) m_mode = M_PAUSE;
                else begin
                    run_elapsed++;
                    new_en = (run_elapsed % TICK_DIV == 0);
                end
            end
            M_PAUSE: begin
                if (c_clr) begin m_mode = M_IDLE; m_rst = 1'b1; end
                else if (c_st || c_ps) m_mode = M_RUN;
            end
            M_DONE: begin
                if (c_clr) begin m_mode = M_IDLE; m_rst = 1'b1; end
                else if (c_st) begin m_mode = M_LOAD; m_load = 1'b1; end
                else begin
                    done_elapsed++;
                    if (done_elapsed == DONE_HOLD * TICK_DIV) m_mode = M_IDLE;
                end
            end
            default: m_mode = M_IDLE;
        endcase
        m_en = new_en;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            model_reset();
        end else begin
            model_step();
            exp_q.push_back(model_vec());
        end
    end

    // Monitor: compares one expected vector per cycle, away from the edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            check("cycle_outputs", dut_vec, exp_q.pop_front());
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input bit s, input bit p, input bit c);
        start_btn = s;
        pause_btn = p;
        clear_btn = c;
        cyc(1);
        start_btn = 1'b0;
        pause_btn = 1'b0;
        clear_btn = 1'b0;
    endtask

    // Asserts reset between edges, checks outputs clear at once, and
    // releases it again just after a rising edge.
    task automatic do_reset_mid();
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset", dut_vec, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int guard;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", dut_vec, 8'h00);
        reset = 1'b0;
        cyc(2);

        // Start, run, pause with two prescaler counts retained, resume
        press(1'b1, 1'b0, 1'b0);
        cyc(11);
        press(1'b0, 1'b1, 1'b0);
        cyc(30);
        press(1'b0, 1'b1, 1'b0);
        cyc(14);
        press(1'b0, 1'b0, 1'b1);
        cyc(5);

        // Terminal coincident with a strobe, then timed DONE
        press(1'b1, 1'b0, 1'b0);
        guard = 0;
        while (m_mode != M_DONE && guard < 200) begin
            @(posedge clk);
            #1;
            cnt_terminal = m_en;
            guard++;
        end
        cnt_terminal = 1'b0;
        check("reach_done", {5'b0, state}, 8'd4);
        cyc(16);

        // Start and clear together while running: clear wins
        press(1'b1, 1'b0, 1'b0);
        cyc(8);
        press(1'b1, 1'b0, 1'b1);
        cyc(6);

        // Held start gives one load; a later pause still pauses
        start_btn = 1'b1;
        cyc(50);
        start_btn = 1'b0;
        cyc(5);
        press(1'b0, 1'b1, 1'b0);
        cyc(6);
        check("held_then_pause", {5'b0, state}, 8'd3);

        // Resume, then reset mid-run; no strobes afterwards
        press(1'b1, 1'b0, 1'b0);
        cyc(6);
        do_reset_mid();
        cyc(20);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 8) start_btn = ~start_btn;
            if ($urandom_range(99) < 8) pause_btn = ~pause_btn;
            if ($urandom_range(99) < 3) clear_btn = ~clear_btn;
            cnt_terminal = ($urandom_range(3) == 0);
            if ($urandom_range(599) == 0) do_reset_mid();
            else cyc(1);
        end

        start_btn    = 1'b0;
        pause_btn    = 1'b0;
        clear_btn    = 1'b0;
        cnt_terminal = 1'b0;
        cyc(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/slp_timer_ctrl.md
# slp_timer_ctrl

Sequencing controller for the 3-digit BCD seven-segment counter chain. Converts raw start/pause/clear push-buttons into clean counter control: one-cycle load and clear pulses plus a prescaled count-enable strobe. Watches the counter's terminal flag to stop the run and hold a timed DONE indication. Sits between the board buttons and the counter's `enable`/`reset`/`load` inputs.

## Interface
- `TICK_DIV`, 50_000_000: clk cycles per count-enable strobe; legal ≥ 2.
- `DONE_HOLD`, 8: number of prescaler ticks DONE is held before auto-return to IDLE; legal ≥ 1.

- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start_btn`  in  1  raw asynchronous button, active-high.
- `pause_btn`  in  1  raw asynchronous button, active-high.
- `clear_btn`  in  1  raw asynchronous button, active-high.
- `cnt_terminal`  in  1  counter terminal flag (combinational, qualified by enable).
- `cnt_enable`  out  1  count-enable strobe to counter.
- `cnt_reset`  out  1  one-cycle clear pulse to counter.
- `cnt_load`  out  1  one-cycle load pulse to counter.
- `busy`  out  1  high in LOAD, RUN, PAUSE.
- `done`  out  1  high in DONE.
- `state`  out  3  encoded state: IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4.

## Operation
- Each button: 2-flop synchronizer, then rising-edge detect. One command pulse per press; a held button never repeats.
- Simultaneous commands in the same cycle: clear > start > pause.
- Prescaler: counts 0..TICK_DIV-1. It runs only in RUN and DONE, freezes in PAUSE, and zeroes in IDLE and LOAD. "Tick" = prescaler at TICK_DIV-1.
- IDLE: all strobes low.
  - start → LOAD.
  - clear → `cnt_reset` pulse, stay IDLE.
- LOAD: exactly one cycle with `cnt_load`=1, then → RUN.
- RUN: `cnt_enable`=1 for exactly one cycle per tick, else 0.
  - clear → IDLE with `cnt_reset` pulse.
  - start → ignored.
  - pause → PAUSE.
  - `cnt_enable`=1 with `cnt_terminal`=1 in the same cycle → DONE. That strobe still reaches the counter, so it wraps.
- PAUSE: `cnt_enable`=0, prescaler value retained.
  - pause or start → RUN; counting resumes from the retained prescaler value.
  - clear → IDLE with `cnt_reset` pulse.
- DONE: `done`=1, `cnt_enable`=0, hold counter counts ticks.
  - After DONE_HOLD ticks → IDLE.
  - start → LOAD.
  - clear → IDLE with `cnt_reset` pulse.
  - pause → ignored.
- `cnt_terminal` is ignored outside RUN.

## Timing
- All outputs are registered; none is combinational from inputs.
- Reset values: state=IDLE, `cnt_enable`=`cnt_reset`=`cnt_load`=`busy`=`done`=0; prescaler, hold counter and sync flops = 0.
- Reset asserted mid-operation: immediate return to IDLE, all outputs 0 asynchronously. No `cnt_reset` pulse is generated by reset itself.
- Command latency: a button sampled high at edge N sets the edge-detect at N+1. The FSM acts at edge N+2, and outputs change after N+2.
- `cnt_load`, `cnt_reset`: exactly one cycle wide, asserted in the cycle following the acting edge.
- First `cnt_enable` after LOAD occurs TICK_DIV cycles after RUN entry. Strobes are then exactly TICK_DIV cycles apart while in RUN.
- Leaving RUN forces `cnt_enable` low in the very next cycle; no partial strobe.
- DONE lasts exactly DONE_HOLD×TICK_DIV cycles absent commands.
- Prescaler and hold counter widths: clog2 of their limits; no overflow, they wrap to 0 at the limit.

## Test plan
- Reset/idle: assert reset mid-RUN → state=0 and all outputs 0 immediately. After release, no strobe for 20 cycles.
- Start and run (TICK_DIV=4): press start at edge N → `cnt_load` high during cycle N+2..N+3, state=2 from N+3. `cnt_enable` strobes at N+7, N+11, N+15.
- Pause/resume: pause after second strobe with prescaler=2 → no strobes for 30 cycles. Resume → next strobe 2 cycles after RUN re-entry, then every 4.
- Terminal: drive `cnt_terminal`=1 coincident with a strobe → state=4, `done`=1. With DONE_HOLD=3, back to IDLE after 12 cycles.
- Simultaneous start+clear in RUN → clear wins: one `cnt_reset` pulse, state=0, no `cnt_load`.
- Held button: start held high 50 cycles from IDLE → exactly one `cnt_load` pulse. A later pause press still produces PAUSE.
